// File: rtl/bf16_stream_accumulator_pkg.sv
// bf16_stream_accumulator_pkg
// Shared BF16 field layout, special encodings, FSM state encoding and small
// classification helpers used by the stream accumulator and its testbench.
package bf16_stream_accumulator_pkg;

    localparam int BIAS   = 127;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 7;
    // hidden bit + 7 mantissa bits + guard/round/sticky
    localparam int EXT_W  = 11;
    // extended mantissa plus carry-out
    localparam int SUM_W  = 12;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;
    localparam logic [15:0]      QNAN    = 16'h7FC0;
    localparam logic [15:0]      PINF    = 16'h7F80;
    localparam logic [15:0]      NINF    = 16'hFF80;
    localparam logic [15:0]      PZERO   = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_OUT   = 3'd4
    } acc_state_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } bf16_t;

    function automatic logic is_nan(input bf16_t v);
        return (v.exp == EXP_MAX) && (v.mant != '0);
    endfunction

    function automatic logic is_inf(input bf16_t v);
        return (v.exp == EXP_MAX) && (v.mant == '0);
    endfunction

    // Unsigned magnitude used for operand ordering; exp==0 counts as zero
    // because subnormals are flushed.
    function automatic logic [EXP_W+MANT_W-1:0] magnitude(input bf16_t v);
        return (v.exp == '0) ? '0 : {v.exp, v.mant};
    endfunction

    // Mantissa with hidden bit and three empty guard/round/sticky positions.
    function automatic logic [EXT_W-1:0] expand(input bf16_t v);
        return (v.exp == '0) ? '0 : {1'b1, v.mant, 3'b000};
    endfunction

endpackage

// File: rtl/bf16_stream_accumulator_if.sv
// bf16_stream_accumulator_if
// Input element stream and output result stream of the accumulator.
// master: producer of elements / consumer of results; slave: the accumulator.
interface bf16_stream_accumulator_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/bf16_stream_accumulator_lzc.sv
// bf16_lzc
// 12-bit combinational leading-zero counter; an all-zero input reports 12.
module bf16_lzc (
    input  logic [11:0] data_i,
    output logic [3:0]  count_o
);

    // Scan upward so the highest set bit determines the final count.
    always_comb begin
        count_o = 4'd12;
        for (int i = 0; i < 12; i++) begin
            if (data_i[i]) begin
                count_o = 4'(11 - i);
            end
        end
    end

endmodule

// File: rtl/bf16_stream_accumulator.sv
// bf16_stream_accumulator
// Accumulates an in_last-terminated stream of BF16 words with a four-cycle
// IDLE/ALIGN/ADD/NORM loop and presents the sum and element count in OUT.
// Build option: define BF16_ACC_RNE_EN for round-to-nearest-even; otherwise
// results are truncated toward zero like the upstream adder.
module bf16_stream_accumulator
    import bf16_stream_accumulator_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    bf16_stream_accumulator_if.slave bus
);

    acc_state_e       state_q, state_d;
    logic             rdy_en_q;
    logic [15:0]      acc_q;
    logic [15:0]      op_q;
    logic             last_q;
    logic [CNT_W-1:0] cnt_q;

    logic             sign_q;
    logic             sub_q;
    logic [EXP_W-1:0] exp_q;
    logic [EXT_W-1:0] ma_q;
    logic [EXT_W-1:0] mb_q;
    logic             spec_q;
    logic [15:0]      spec_val_q;
    logic [SUM_W-1:0] sum_q;

    logic             accept_w;
    logic             in_ready_w;
    logic             out_valid_w;
    logic [15:0]      out_data_w;
    logic [CNT_W-1:0] out_count_w;

    bf16_t            acc_w;
    bf16_t            op_w;
    bf16_t            big_w;
    bf16_t            small_w;
    logic             swap_w;
    logic [EXP_W-1:0] diff_w;
    logic [EXT_W-1:0] big_ext_w;
    logic [EXT_W-1:0] small_full_w;
    logic [EXT_W-1:0] small_ext_w;
    logic [EXT_W-1:0] lost_mask_w;
    logic             spec_w;
    logic [15:0]      spec_val_w;

    logic [3:0]        lz_w;
    logic [3:0]        shamt_w;
    logic [EXT_W-1:0]  norm_m_w;
    logic signed [9:0] norm_e_w;
    logic              round_up_w;
    logic [8:0]        mant8_w;
    logic [MANT_W-1:0] rnd_mant_w;
    logic signed [9:0] rnd_e_w;
    logic [15:0]       result_w;

    assign acc_w    = bf16_t'(acc_q);
    assign op_w     = bf16_t'(op_q);
    assign accept_w = (state_q == ST_IDLE) && rdy_en_q && bus.in_valid;

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = out_data_w;
    assign bus.out_count = out_count_w;

    // State register; rdy_en_q keeps in_ready low for the first cycle after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Next-state and handshake outputs; results are only visible in OUT.
    always_comb begin
        state_d     = state_q;
        in_ready_w  = 1'b0;
        out_valid_w = 1'b0;
        out_data_w  = '0;
        out_count_w = '0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready_w = rdy_en_q;
                if (accept_w) begin
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: state_d = ST_ADD;
            ST_ADD:   state_d = ST_NORM;
            ST_NORM:  state_d = last_q ? ST_OUT : ST_IDLE;
            ST_OUT: begin
                out_valid_w = 1'b1;
                out_data_w  = acc_q;
                out_count_w = cnt_q;
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Order operands by magnitude and right-shift the smaller one, folding
    // every shifted-out bit into the sticky position.
    always_comb begin
        swap_w       = magnitude(op_w) > magnitude(acc_w);
        big_w        = swap_w ? op_w : acc_w;
        small_w      = swap_w ? acc_w : op_w;
        diff_w       = big_w.exp - small_w.exp;
        big_ext_w    = expand(big_w);
        small_full_w = expand(small_w);
        lost_mask_w  = '0;
        if (diff_w >= 8'd11) begin
            small_ext_w = {{(EXT_W-1){1'b0}}, |small_full_w};
        end else begin
            lost_mask_w = ~({EXT_W{1'b1}} << diff_w);
            small_ext_w = (small_full_w >> diff_w)
                        | {{(EXT_W-1){1'b0}}, |(small_full_w & lost_mask_w)};
        end
    end

    // NaN and infinity operands bypass the datapath with a fixed result.
    always_comb begin
        spec_w     = 1'b1;
        spec_val_w = QNAN;
        if (is_nan(acc_w) || is_nan(op_w)) begin
            spec_val_w = QNAN;
        end else if (is_inf(acc_w) && is_inf(op_w)) begin
            spec_val_w = (acc_w.sign != op_w.sign) ? QNAN : acc_q;
        end else if (is_inf(acc_w)) begin
            spec_val_w = acc_q;
        end else if (is_inf(op_w)) begin
            spec_val_w = op_q;
        end else begin
            spec_w = 1'b0;
        end
    end

    bf16_lzc u_lzc (
        .data_i  (sum_q),
        .count_o (lz_w)
    );

    // Normalize the raw sum so the hidden bit sits at bit 10, round, then
    // apply zero, underflow and overflow encodings.
    always_comb begin
        shamt_w = lz_w - 4'd1;
        if (sum_q[SUM_W-1]) begin
            norm_m_w = {sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
            norm_e_w = $signed({2'b00, exp_q}) + 10'sd1;
        end else begin
            norm_m_w = sum_q[EXT_W-1:0] << shamt_w;
            norm_e_w = $signed({2'b00, exp_q}) - $signed({6'b000000, shamt_w});
        end
`ifdef BF16_ACC_RNE_EN
        round_up_w = norm_m_w[2] & (norm_m_w[3] | norm_m_w[1] | norm_m_w[0]);
`else
        round_up_w = 1'b0;
`endif
        mant8_w = {1'b0, norm_m_w[EXT_W-1:3]} + {8'b0, round_up_w};
        if (mant8_w[8]) begin
            rnd_mant_w = '0;
            rnd_e_w    = norm_e_w + 10'sd1;
        end else begin
            rnd_mant_w = mant8_w[MANT_W-1:0];
            rnd_e_w    = norm_e_w;
        end
        if (spec_q) begin
            result_w = spec_val_q;
        end else if (sum_q == '0) begin
            result_w = PZERO;
        end else if (rnd_e_w <= 10'sd0) begin
            result_w = PZERO;
        end else if (rnd_e_w >= 10'sd255) begin
            result_w = sign_q ? NINF : PINF;
        end else begin
            result_w = {sign_q, rnd_e_w[EXP_W-1:0], rnd_mant_w};
        end
    end

    // Element capture, saturating count and accumulator write-back/clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            last_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= PZERO;
        end else begin
            if (accept_w) begin
                op_q   <= bus.in_data;
                last_q <= bus.in_last;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            if (state_q == ST_NORM) begin
                acc_q <= result_w;
            end
            if ((state_q == ST_OUT) && bus.out_ready) begin
                acc_q <= PZERO;
                cnt_q <= '0;
            end
        end
    end

    // Aligned operands and special-case result held for the ADD/NORM stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q     <= 1'b0;
            sub_q      <= 1'b0;
            exp_q      <= '0;
            ma_q       <= '0;
            mb_q       <= '0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
        end else if (state_q == ST_ALIGN) begin
            sign_q     <= big_w.sign;
            sub_q      <= big_w.sign ^ small_w.sign;
            exp_q      <= big_w.exp;
            ma_q       <= big_ext_w;
            mb_q       <= small_ext_w;
            spec_q     <= spec_w;
            spec_val_q <= spec_val_w;
        end
    end

    // Signed-magnitude add; ordering guarantees the difference is non-negative.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (state_q == ST_ADD) begin
            sum_q <= sub_q ? ({1'b0, ma_q} - {1'b0, mb_q})
                           : ({1'b0, ma_q} + {1'b0, mb_q});
        end
    end

endmodule

// File: tb/tb_bf16_stream_accumulator.sv
// tb_bf16_stream_accumulator
// Directed stimulus for the BF16 stream accumulator; expected results are
// queued when a vector's last element is driven and checked when OUT appears.
module tb_bf16_stream_accumulator;

    typedef struct {
        logic [15:0] data;
        logic [7:0]  count;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    bf16_stream_accumulator_if #(.CNT_W(8)) bus ();

    bf16_stream_accumulator #(.CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Hard stop in case a handshake never completes.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point; every check goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one element and wait (bounded) for it to be accepted; the last
    // element of a vector pushes the expected result onto the scoreboard.
    task automatic applyStimulus(input logic [15:0] data, input logic last,
                                 input logic [15:0] expData, input logic [7:0] expCount);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_last  = last;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("accept", 32'(bus.in_ready), 32'd1);
        if (last) begin
            e.data  = expData;
            e.count = expCount;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Wait for a result, compare it against the scoreboard head, then accept it.
    task automatic drainResult(input string tag);
        int   n = 0;
        exp_t e;
        while (bus.out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        checkOutput({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput({tag, "_data"}, 32'(bus.out_data), 32'(e.data));
            checkOutput({tag, "_count"}, 32'(bus.out_count), 32'(e.count));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput({tag, "_released"}, 32'(bus.out_valid), 32'd0);
    endtask

    // Directed sequence of vectors covering arithmetic, specials, stalls and reset.
    initial begin
        int n;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
        checkOutput("rst_out_count", 32'(bus.out_count), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("rst_in_ready_first", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        checkOutput("rst_in_ready_after", 32'(bus.in_ready), 32'd1);

        $display("[TB] T1 1.0 + 1.0");
        applyStimulus(16'h3F80, 1'b0, 16'h0, 8'd0);
        applyStimulus(16'h3F80, 1'b1, 16'h4000, 8'd2);
        drainResult("T1");

        $display("[TB] T2 exact cancellation");
        applyStimulus(16'h3F80, 1'b0, 16'h0, 8'd0);
        applyStimulus(16'hBF80, 1'b1, 16'h0000, 8'd2);
        drainResult("T2");

        $display("[TB] T3 overflow and inf - inf");
        applyStimulus(16'h7F7F, 1'b0, 16'h0, 8'd0);
        applyStimulus(16'h7F7F, 1'b1, 16'h7F80, 8'd2);
        drainResult("T3_ovf");
        applyStimulus(16'h7F80, 1'b0, 16'h0, 8'd0);
        applyStimulus(16'hFF80, 1'b1, 16'h7FC0, 8'd2);
        drainResult("T3_nan");

        $display("[TB] T4 rounding");
        applyStimulus(16'h3F81, 1'b0, 16'h0, 8'd0);
`ifdef BF16_ACC_RNE_EN
        applyStimulus(16'h3B80, 1'b1, 16'h3F82, 8'd2);
`else
        applyStimulus(16'h3B80, 1'b1, 16'h3F81, 8'd2);
`endif
        drainResult("T4");

        $display("[TB] mixed-sign three element vector");
        applyStimulus(16'h4040, 1'b0, 16'h0, 8'd0);
        applyStimulus(16'hBF80, 1'b0, 16'h0, 8'd0);
        applyStimulus(16'h3F00, 1'b1, 16'h4020, 8'd3);
        drainResult("mixed");

        $display("[TB] subtraction with left normalization");
        applyStimulus(16'h3F80, 1'b0, 16'h0, 8'd0);
        applyStimulus(16'hBF00, 1'b1, 16'h3F00, 8'd2);
        drainResult("subnorm");

        $display("[TB] NaN input is sticky");
        applyStimulus(16'h7FC1, 1'b0, 16'h0, 8'd0);
        applyStimulus(16'h3F80, 1'b1, 16'h7FC0, 8'd2);
        drainResult("nan");

        $display("[TB] T5 output stall");
        applyStimulus(16'h4000, 1'b0, 16'h0, 8'd0);
        applyStimulus(16'h4000, 1'b1, 16'h4080, 8'd2);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            checkOutput("T5_hold_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("T5_hold_data", 32'(bus.out_data), 32'h4080);
            checkOutput("T5_hold_count", 32'(bus.out_count), 32'd2);
            checkOutput("T5_hold_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        drainResult("T5");

        $display("[TB] T6 reset mid-vector");
        applyStimulus(16'h3F80, 1'b0, 16'h0, 8'd0);
        applyStimulus(16'h4000, 1'b0, 16'h0, 8'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("T6_in_ready_first", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("T6_no_out", 32'(bus.out_valid), 32'd0);
        end
        applyStimulus(16'h4000, 1'b1, 16'h4000, 8'd1);
        drainResult("T6");

        $display("[TB] count saturation");
        for (int i = 0; i < 300; i++) begin
            applyStimulus((i == 299) ? 16'h3F80 : 16'h0000, (i == 299), 16'h3F80, 8'd255);
        end
        drainResult("sat");

        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
